dna_top: RTL and testbench



---
 rtl/dna_top.sv | 227 ++++++++++++++++++++++
 tb/tb_dna_top.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dna_top.sv
// Smith-Waterman tile engine: one 16-base read word against N consecutive 16-base
// reference strips, one 16-cell score row per cycle, with a running best score.
module dna_top (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [6:0]  ADDR_WIDTH,
  input  logic [2:0]  match,
  input  logic [2:0]  mismatch,
  input  logic [2:0]  gap,
  input  logic [31:0] ref_32_i,
  input  logic [31:0] read_32_i,
  output logic        en_o,
  output logic [31:0] addr_ref_o,
  output logic [31:0] addr_read_o,
  output logic [31:0] addr_matrix_o,
  output logic [31:0] matrix_o0,
  output logic [31:0] matrix_o1,
  output logic [31:0] matrix_o2,
  output logic [31:0] matrix_o3,
  output logic [31:0] matrix_o4,
  output logic [31:0] matrix_o5,
  output logic [31:0] matrix_o6,
  output logic [31:0] matrix_o7,
  output logic [31:0] matrix_o8,
  output logic [31:0] matrix_o9,
  output logic [31:0] matrix_o10,
  output logic [31:0] matrix_o11,
  output logic [31:0] matrix_o12,
  output logic [31:0] matrix_o13,
  output logic [31:0] matrix_o14,
  output logic [31:0] matrix_o15,
  output logic [3:0]  count,
  output logic [31:0] read_prv_i,
  output logic [31:0] read_i,
  output logic [31:0] score_i
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, COMP, DONE} state_e;

  state_e      state_q, state_d;
  logic [6:0]  strip_q, strip_d, nstrip_q, nstrip_d;
  logic [3:0]  k_q, k_d, count_q, count_d;
  logic [2:0]  match_q, match_d, mism_q, mism_d, gap_q, gap_d;
  logic [31:0] ref_q, ref_d, read_q, read_d;
  logic [31:0] up_q [16];
  logic [31:0] up_d [16];
  logic [31:0] bnd_q [16];
  logic [31:0] bnd_d [16];
  logic [31:0] mat_q [16];
  logic [31:0] mat_d [16];
  logic [31:0] bdiag_q, bdiag_d, amat_q, amat_d, prv_q, prv_d, score_q, score_d;
  logic        en_q, en_d;

  logic        calc;
  logic [3:0]  row;
  logic [31:0] ref_w, read_w, rmax;
  logic [1:0]  rbase, pbase;
  logic [31:0] h [16];

  // Row 0 is evaluated during LOAD straight from the memory buses, so each
  // row lands on the edge that also advances the row counter.
  always_comb begin
    logic signed [33:0] best, cand, left, sc;
    logic [31:0] dprev;
    calc   = (state_q == LOAD) || (state_q == COMP && k_q != 4'd15);
    row    = (state_q == LOAD) ? 4'd0 : k_q + 4'd1;
    ref_w  = (state_q == LOAD) ? ref_32_i : ref_q;
    read_w = (state_q == LOAD && strip_q == 7'd0) ? read_32_i : read_q;
    rbase  = 2'(read_w >> {row, 1'b0});
    pbase  = 2'(read_w >> {row - 4'd1, 1'b0});
    left   = {2'b00, bnd_q[row]};
    dprev  = bdiag_q;
    rmax   = '0;
    for (int unsigned c = 0; c < 16; c++) begin
      sc   = (ref_w[2*c +: 2] == rbase) ? {31'b0, match_q} : -{31'b0, mism_q};
      best = '0;
      cand = {2'b00, dprev} + sc;
      if (cand > best) best = cand;
      cand = {2'b00, up_q[c]} - {31'b0, gap_q};
      if (cand > best) best = cand;
      cand = left - {31'b0, gap_q};
      if (cand > best) best = cand;
      h[c]  = best[31:0];
      left  = best;
      dprev = up_q[c];
      if (h[c] > rmax) rmax = h[c];
    end
  end

  always_comb begin
    state_d  = state_q;
    strip_d  = strip_q;
    nstrip_d = nstrip_q;
    k_d      = k_q;
    match_d  = match_q;
    mism_d   = mism_q;
    gap_d    = gap_q;
    ref_d    = ref_q;
    read_d   = read_q;
    up_d     = up_q;
    bnd_d    = bnd_q;
    mat_d    = mat_q;
    bdiag_d  = bdiag_q;
    amat_d   = amat_q;
    prv_d    = prv_q;
    score_d  = score_q;
    count_d  = count_q;
    en_d     = calc;

    if (calc) begin
      mat_d      = h;
      up_d       = h;
      bnd_d[row] = h[15];
      bdiag_d    = bnd_q[row];  // previous strip's column 15, diag of the next row
      count_d    = row;
      amat_d     = {21'b0, strip_q, row};
      prv_d      = (row == 4'd0) ? '0 : {30'b0, pbase};
      score_d    = (rmax > score_q) ? rmax : score_q;
    end

    unique case (state_q)
      IDLE: if (start_i) begin
        state_d  = FETCH;
        match_d  = match;
        mism_d   = mismatch;
        gap_d    = gap;
        nstrip_d = (ADDR_WIDTH == 7'd0) ? 7'd1 : ADDR_WIDTH;
        strip_d  = '0;
        score_d  = '0;
        for (int unsigned i = 0; i < 16; i++) bnd_d[i] = '0;
      end
      FETCH: begin
        state_d = LOAD;
        bdiag_d = '0;
        for (int unsigned i = 0; i < 16; i++) up_d[i] = '0;
      end
      LOAD: begin
        state_d = COMP;
        ref_d   = ref_32_i;
        k_d     = '0;
        if (strip_q == 7'd0) read_d = read_32_i;
      end
      COMP: begin
        k_d = k_q + 4'd1;
        if (k_q == 4'd15) begin
          if ({1'b0, strip_q} + 8'd1 < {1'b0, nstrip_q}) begin
            strip_d = strip_q + 7'd1;
            state_d = FETCH;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      strip_q  <= '0;
      nstrip_q <= '0;
      k_q      <= '0;
      match_q  <= '0;
      mism_q   <= '0;
      gap_q    <= '0;
      ref_q    <= '0;
      read_q   <= '0;
      up_q     <= '{default: '0};
      bnd_q    <= '{default: '0};
      mat_q    <= '{default: '0};
      bdiag_q  <= '0;
      amat_q   <= '0;
      prv_q    <= '0;
      score_q  <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      strip_q  <= strip_d;
      nstrip_q <= nstrip_d;
      k_q      <= k_d;
      match_q  <= match_d;
      mism_q   <= mism_d;
      gap_q    <= gap_d;
      ref_q    <= ref_d;
      read_q   <= read_d;
      up_q     <= up_d;
      bnd_q    <= bnd_d;
      mat_q    <= mat_d;
      bdiag_q  <= bdiag_d;
      amat_q   <= amat_d;
      prv_q    <= prv_d;
      score_q  <= score_d;
      count_q  <= count_d;
      en_q     <= en_d;
    end
  end

  assign en_o          = en_q;
  assign addr_ref_o    = {25'b0, strip_q};
  assign addr_read_o   = '0;
  assign addr_matrix_o = amat_q;
  assign count         = count_q;
  assign read_prv_i    = prv_q;
  assign read_i        = read_q;
  assign score_i       = score_q;
  assign matrix_o0     = mat_q[0];
  assign matrix_o1     = mat_q[1];
  assign matrix_o2     = mat_q[2];
  assign matrix_o3     = mat_q[3];
  assign matrix_o4     = mat_q[4];
  assign matrix_o5     = mat_q[5];
  assign matrix_o6     = mat_q[6];
  assign matrix_o7     = mat_q[7];
  assign matrix_o8     = mat_q[8];
  assign matrix_o9     = mat_q[9];
  assign matrix_o10    = mat_q[10];
  assign matrix_o11    = mat_q[11];
  assign matrix_o12    = mat_q[12];
  assign matrix_o13    = mat_q[13];
  assign matrix_o14    = mat_q[14];
  assign matrix_o15    = mat_q[15];

endmodule

// File: tb/tb_dna_top.sv
// Bench for dna_top: whole-matrix Smith-Waterman reference over all strips,
// directed plan cases plus randomized jobs, mid-job reset and back-to-back start.
module tb_dna_top;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [6:0]  aw_in = '0;
  logic [2:0]  m_in = '0, mm_in = '0, g_in = '0;
  logic [31:0] ref_mem [128];
  logic [31:0] read_word = '0;
  logic [31:0] ref_32_i, read_32_i;
  logic        en_o;
  logic [31:0] addr_ref_o, addr_read_o, addr_matrix_o, read_prv_i, read_i, score_i;
  logic [3:0]  count;
  logic [31:0] mo [16];

  int n_cmp = 0;
  int n_err = 0;
  int exp_h [16][64];
  int exp_best;

  assign ref_32_i  = ref_mem[addr_ref_o[6:0]];
  assign read_32_i = read_word;

  always #5 clk = ~clk;

  dna_top dut (
    .clk(clk), .rst(rst), .start_i(start_i), .ADDR_WIDTH(aw_in),
    .match(m_in), .mismatch(mm_in), .gap(g_in),
    .ref_32_i(ref_32_i), .read_32_i(read_32_i),
    .en_o(en_o), .addr_ref_o(addr_ref_o), .addr_read_o(addr_read_o),
    .addr_matrix_o(addr_matrix_o),
    .matrix_o0(mo[0]), .matrix_o1(mo[1]), .matrix_o2(mo[2]), .matrix_o3(mo[3]),
    .matrix_o4(mo[4]), .matrix_o5(mo[5]), .matrix_o6(mo[6]), .matrix_o7(mo[7]),
    .matrix_o8(mo[8]), .matrix_o9(mo[9]), .matrix_o10(mo[10]), .matrix_o11(mo[11]),
    .matrix_o12(mo[12]), .matrix_o13(mo[13]), .matrix_o14(mo[14]), .matrix_o15(mo[15]),
    .count(count), .read_prv_i(read_prv_i), .read_i(read_i), .score_i(score_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Full 16 x 16n local-alignment matrix, textbook recurrence with zero borders.
  task automatic model(input int n, input int m, input int mm, input int g);
    int rb, cb, s, d, u, l, v;
    exp_best = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16 * n; j++) begin
        rb = int'((read_word >> (2 * i)) & 32'd3);
        cb = int'((ref_mem[j / 16] >> (2 * (j % 16))) & 32'd3);
        s  = (rb == cb) ? m : -mm;
        d  = (i > 0 && j > 0) ? exp_h[i-1][j-1] : 0;
        u  = (i > 0) ? exp_h[i-1][j] : 0;
        l  = (j > 0) ? exp_h[i][j-1] : 0;
        v  = 0;
        if (d + s > v) v = d + s;
        if (u - g > v) v = u - g;
        if (l - g > v) v = l - g;
        exp_h[i][j] = v;
        if (v > exp_best) exp_best = v;
      end
    end
  endtask

  task automatic check_zero(input string name);
    chk({name, " en"}, {31'b0, en_o}, 32'd0);
    chk({name, " addr_ref"}, addr_ref_o, 32'd0);
    chk({name, " addr_read"}, addr_read_o, 32'd0);
    chk({name, " addr_matrix"}, addr_matrix_o, 32'd0);
    chk({name, " count"}, {28'b0, count}, 32'd0);
    chk({name, " read_prv"}, read_prv_i, 32'd0);
    chk({name, " read_i"}, read_i, 32'd0);
    chk({name, " score"}, score_i, 32'd0);
    for (int c = 0; c < 16; c++) chk($sformatf("%s m%0d", name, c), mo[c], 32'd0);
  endtask

  // pre: start already driven at the previous negedge; chain: start the next job
  // the first cycle the block can be back in IDLE.
  task automatic run_job(input string name, input logic [6:0] aw, input logic [2:0] m,
                         input logic [2:0] mm, input logic [2:0] g, input bit pre,
                         input bit chain);
    int n, t, k, r;
    bit exp_en;
    logic [31:0] pv;
    n = (aw == 7'd0) ? 1 : int'(aw);
    model(n, int'(m), int'(mm), int'(g));
    if (!pre) begin
      @(negedge clk);
      aw_in = aw; m_in = m; mm_in = mm; g_in = g;
      start_i = 1'b1;
    end
    @(posedge clk);
    #1;
    start_i = 1'b0;
    aw_in = 7'($urandom); m_in = 3'($urandom); mm_in = 3'($urandom); g_in = 3'($urandom);
    t = 0;
    for (int e = 1; e <= 18 * n + 2; e++) begin
      @(negedge clk);
      exp_en = (e >= 3) && (e <= 18 * n) && (((e - 3) % 18) < 16);
      chk($sformatf("%s en e%0d", name, e), {31'b0, en_o}, {31'b0, exp_en});
      if (exp_en && en_o) begin
        k = (e - 3) / 18;
        r = (e - 3) % 18;
        for (int c = 0; c < 16; c++)
          chk($sformatf("%s H s%0d r%0d c%0d", name, k, r, c), mo[c], exp_h[r][16*k+c]);
        chk($sformatf("%s count s%0d r%0d", name, k, r), {28'b0, count}, r);
        chk($sformatf("%s addr_matrix s%0d r%0d", name, k, r), addr_matrix_o, 16 * k + r);
        chk($sformatf("%s addr_ref s%0d r%0d", name, k, r), addr_ref_o, k);
        pv = (r == 0) ? 32'd0 : ((read_word >> (2 * (r - 1))) & 32'd3);
        chk($sformatf("%s read_prv s%0d r%0d", name, k, r), read_prv_i, pv);
        chk($sformatf("%s read_i s%0d r%0d", name, k, r), read_i, read_word);
        t++;
      end
      if (e == 10) start_i = 1'b1;
      if (e == 11) start_i = 1'b0;
      if (e == 18 * n + 2) begin
        aw_in = aw; m_in = m; mm_in = mm; g_in = g;
        if (chain) start_i = 1'b1;
      end
    end
    chk({name, " score"}, score_i, exp_best);
    chk({name, " rows"}, t, 16 * n);
    chk({name, " addr_read"}, addr_read_o, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b1;
    @(negedge clk);
    check_zero("idle");

    read_word = 32'h0;
    run_job("zeros", 7'd1, 3'd2, 3'd1, 3'd2, 1'b0, 1'b0);
    chk("zeros row15 c15", mo[15], 32'd32);
    chk("zeros score32", score_i, 32'd32);

    read_word = 32'h5555_5555;
    run_job("mism", 7'd1, 3'd2, 3'd1, 3'd2, 1'b0, 1'b0);
    chk("mism score0", score_i, 32'd0);

    read_word = 32'h0;
    run_job("two", 7'd2, 3'd2, 3'd1, 3'd2, 1'b0, 1'b1);
    run_job("two_chained", 7'd2, 3'd2, 3'd1, 3'd2, 1'b1, 1'b0);
    chk("two score32", score_i, 32'd32);
    chk("two row15 c15", mo[15], 32'd32);

    read_word = 32'hFFFF_FFFC;
    ref_mem[0] = 32'h5555_5155;
    run_job("gap", 7'd1, 3'd2, 3'd1, 3'd1, 1'b0, 1'b0);
    chk("gap model c5", exp_h[0][5], 32'd2);
    chk("gap model c6", exp_h[0][6], 32'd1);

    ref_mem[0] = $urandom;
    read_word = $urandom;
    run_job("aw0", 7'd0, 3'd3, 3'd2, 3'd1, 1'b0, 1'b0);

    // abort mid-job with reset, then confirm a clean restart
    @(negedge clk);
    aw_in = 7'd3; m_in = 3'd2; mm_in = 3'd1; g_in = 3'd1; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (24) @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("abort");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("after_abort");

    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 4; i++) ref_mem[i] = $urandom;
      read_word = $urandom;
      run_job($sformatf("rand%0d", j), 7'($urandom_range(0, 3)), 3'($urandom),
              3'($urandom), 3'($urandom), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
